// File: rtl/sub16_serial_pkg.sv
// ============================================================================
//  sub16_serial_pkg
//  Shared definitions for the slice-serial subtractor: FSM states and sizing.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sub16_serial_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int SLICE_DEF    = 4;
    localparam int N_SLICES_DEF = WIDTH_DEF / SLICE_DEF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter needs at least one bit even for a single-slice configuration.
    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W_DEF = cnt_bits(N_SLICES_DEF);

endpackage

`default_nettype wire

// File: rtl/sub16_serial_slice.sv
// ============================================================================
//  sub16_serial_slice
//  Combinational SLICE-bit ripple slice computing a + b_inv + cin.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sub16_serial_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module sub16_serial_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b_inv,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        sub16_serial_fa u_fa (
            .a    (a[i]),
            .b    (b_inv[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[SLICE];

endmodule

`default_nettype wire

// File: rtl/sub16_serial.sv
// ============================================================================
//  sub16_serial
//  Multi-cycle subtractor Diff = A - B - Bin, one SLICE-bit slice per clock.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sub16_serial
    import sub16_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    // The shadow register holds the N-1 finished slices; assumes WIDTH > SLICE.
    localparam int              N_SL = WIDTH / SLICE;
    localparam int              CW   = cnt_bits(N_SL);
    localparam logic [CW-1:0]   LAST = CW'(N_SL - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   accept;
    logic                   last;

    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic                   carry;
    logic                   a_msb;
    logic                   b_msb;
    logic [CW-1:0]          cnt;
    logic [WIDTH-SLICE-1:0] shadow;
    logic [WIDTH-1:0]       shadow_nxt;

    logic [SLICE-1:0]       s;
    logic                   cout;

    sub16_serial_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a     (a_sh[SLICE-1:0]),
        .b_inv (b_sh[SLICE-1:0]),
        .cin   (carry),
        .s     (s),
        .cout  (cout)
    );

    // New slice enters at the top so after N shifts slice 0 sits at bit 0.
    assign shadow_nxt = {s, shadow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            shadow <= '0;
            Diff   <= '0;
            Bout   <= 1'b0;
            Ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_sh  <= A;
                b_sh  <= ~B;
                carry <= ~Bin;
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                a_sh   <= a_sh >> SLICE;
                b_sh   <= b_sh >> SLICE;
                carry  <= cout;
                cnt    <= cnt + CW'(1);
                shadow <= shadow_nxt[WIDTH-1:SLICE];
                if (last) begin
                    cnt  <= '0;
                    Diff <= shadow_nxt;
                    Bout <= ~cout;
                    Ovf  <= (a_msb != b_msb) & (s[SLICE-1] != a_msb);
                end
            end
        end
    end

    assign busy = (state == ST_RUN);

endmodule

`default_nettype wire
